datamemory_sync: RTL

- Synchronous, parametrised single-port data memory; successor to the 16x64 combinational-write data memory in the CPU datapath.
- Adds clocked writes, per-byte write enables, registered reads with valid strobe, req/ready handshake, and a hardware clear sequencer that zeroes the array after reset or on request.
- Sits between the execute stage and writeback.

---
 rtl/dmem_pkg.sv | 31 +++
 rtl/dmem_array.sv | 43 ++++
 rtl/datamemory_sync.sv | 120 ++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the synchronous data memory: FSM state encoding,
// byte-enable width derivation and the per-byte merge used on every write.
package dmem_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  // Widest word the merge helper handles; callers cast in and out of this width.
  localparam int MAX_DATA_W = 512;
  localparam int MAX_BE_W   = MAX_DATA_W / 8;

  function automatic int calc_be_w(input int data_w);
    return data_w / 8;
  endfunction

  function automatic logic [MAX_DATA_W-1:0] byte_merge(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] new_word,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] mask;
    mask = '0;
    for (int i = 0; i < MAX_BE_W; i++) begin
      mask[8*i +: 8] = {8{be[i]}};
    end
    return (old_word & ~mask) | (new_word & mask);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W register array with a byte-masked synchronous write port and a
// registered read port. Range checking is the caller's job.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic [DATA_W/8-1:0]   i_wbe,
  input  logic                  i_re,
  input  logic [ADDR_W-1:0]     i_raddr,
  output logic [DATA_W-1:0]     o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Storage is deliberately not reset; the owner clears it word by word.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= DATA_W'(byte_merge(MAX_DATA_W'(r_mem[i_waddr]),
                                           MAX_DATA_W'(i_wdata),
                                           MAX_BE_W'(i_wbe)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/datamemory_sync.sv
// Single-port synchronous data memory: req/ready handshake, byte-enabled writes,
// 1-cycle registered reads with rvalid, range error strobe and a clear sequencer.
module datamemory_sync
  import dmem_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int ADDR_W = 6,
  parameter  int DEPTH  = 64,
  localparam int BE_W   = calc_be_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              err,
  output logic              busy
);

  localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic              r_rvalid;
  logic              r_err;
  logic              r_rd_oor;

  logic              w_clearing;
  logic              w_ready;
  logic              w_accept;
  logic              w_oor;
  logic              w_arr_we;
  logic [ADDR_W-1:0] w_arr_waddr;
  logic [DATA_W-1:0] w_arr_wdata;
  logic [BE_W-1:0]   w_arr_wbe;
  logic              w_arr_re;
  logic [DATA_W-1:0] w_arr_rdata;

  assign w_clearing = (r_state == ST_CLEAR);
  assign w_ready    = (r_state == ST_IDLE) && !clr;
  assign w_accept   = req && w_ready;
  assign w_oor      = ({1'b0, addr} >= LP_DEPTH);

  // The clear sequencer owns the write port while clearing; requests are locked out.
  assign w_arr_we    = !rst && (w_clearing || (w_accept && we && !w_oor));
  assign w_arr_waddr = w_clearing ? r_clr_ptr : addr;
  assign w_arr_wdata = w_clearing ? '0 : wdata;
  assign w_arr_wbe   = w_clearing ? '1 : be;
  assign w_arr_re    = !rst && w_accept && !we && !w_oor;

  dmem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_arr_we),
    .i_waddr (w_arr_waddr),
    .i_wdata (w_arr_wdata),
    .i_wbe   (w_arr_wbe),
    .i_re    (w_arr_re),
    .i_raddr (addr),
    .o_rdata (w_arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_clr_ptr <= '0;
      r_rvalid  <= 1'b0;
      r_err     <= 1'b0;
      r_rd_oor  <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        ST_CLEAR: begin
          if (r_clr_ptr == LP_LAST) begin
            r_state   <= ST_IDLE;
            r_clr_ptr <= '0;
          end else begin
            r_clr_ptr <= r_clr_ptr + 1'b1;
          end
        end
        ST_IDLE: begin
          if (clr) begin
            r_state   <= ST_CLEAR;
            r_clr_ptr <= '0;
          end else if (req) begin
            r_err <= w_oor;
            if (!we) begin
              r_rvalid <= 1'b1;
              r_rd_oor <= w_oor;
            end
          end
        end
        default: begin
          r_state   <= ST_CLEAR;
          r_clr_ptr <= '0;
        end
      endcase
    end
  end

  assign ready  = w_ready;
  assign busy   = w_clearing;
  assign rvalid = r_rvalid;
  assign err    = r_err;
  // Out-of-range reads present zero without disturbing the array's read register.
  assign rdata  = r_rd_oor ? '0 : w_arr_rdata;

endmodule
